// File: rtl/cpu_pkg.sv
// Types and constants shared by the CPU front-end blocks: the fetch FSM
// state encoding and the NOP instruction word.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/pc_reg.sv
// Word-index program counter with clear, load, increment and optional wrap at
// the last memory word.
module pc_reg #(
    parameter int DEPTH   = 128,
    parameter int WRAP_EN = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        load_i,
    input  logic [31:0] load_pc_i,
    input  logic        inc_i,
    output logic [31:0] pc_o
);

    localparam logic [31:0] LAST_PC = 32'(DEPTH - 1);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_inc;

    // Without wrap the PC is allowed to step one past the last word; the
    // controller treats that value as the end-of-memory marker.
    assign pc_inc = ((WRAP_EN != 0) && (pc_q == LAST_PC)) ? 32'd0 : pc_q + 32'd1;

    always_comb begin
        pc_d = pc_q;
        if (clr_i) begin
            pc_d = 32'd0;
        end else if (load_i) begin
            pc_d = load_pc_i;
        end else if (inc_i) begin
            pc_d = pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= 32'd0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: loads the program into an external memory
// while idle, then streams fetched instructions with one-cycle latency.
module instr_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int DEPTH   = 128,
    parameter int ADDR_W  = 7,
    parameter int WRAP_EN = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              load_valid,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    output logic              load_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_we,
    output logic [31:0]       imem_wdata,
    input  logic [31:0]       imem_rdata,
    output logic              if_valid,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_instr,
    output logic              halted,
    output logic              err
);

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    fetch_state_e state_q, state_d;
    logic         if_valid_q, if_valid_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic [31:0]  if_instr_q, if_instr_d;
    logic         err_q, err_d;

    logic [31:0]  pc;
    logic         pc_clr;
    logic         pc_load;
    logic         pc_inc;
    logic         pc_past_end;

    pc_reg #(
        .DEPTH   (DEPTH),
        .WRAP_EN (WRAP_EN)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (pc_clr),
        .load_i    (pc_load),
        .load_pc_i (redirect_pc),
        .inc_i     (pc_inc),
        .pc_o      (pc)
    );

    assign pc_past_end = (WRAP_EN == 0) && (pc == DEPTH_W);

    always_comb begin
        state_d    = state_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        err_d      = err_q;
        pc_clr     = 1'b0;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;
        case (state_q)
            IDLE: begin
                if_valid_d = 1'b0;
                if (start && !load_valid) begin
                    state_d = RUN;
                    pc_clr  = 1'b1;
                end
            end
            RUN: begin
                // Redirect outranks stall and end-of-memory; the fetch at the
                // old PC is dropped, leaving one bubble.
                if (redirect_valid) begin
                    if_valid_d = 1'b0;
                    if (redirect_pc < DEPTH_W) begin
                        pc_load = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        state_d = HALT;
                    end
                end else if (pc_past_end) begin
                    if_valid_d = 1'b0;
                    state_d    = HALT;
                end else if (!stall) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = pc;
                    if_instr_d = imem_rdata;
                    pc_inc     = 1'b1;
                end
            end
            HALT: begin
                if_valid_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            if_valid_q <= 1'b0;
            if_pc_q    <= 32'd0;
            if_instr_q <= NOP;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            err_q      <= err_d;
        end
    end

    // The memory port belongs to the loader while idle, to the fetch path otherwise.
    assign load_ready = (state_q == IDLE) && load_valid && !rst;
    assign imem_we    = load_ready;
    assign imem_addr  = (state_q == IDLE) ? load_addr : pc[ADDR_W-1:0];
    assign imem_wdata = (state_q == IDLE) ? load_data : NOP;

    assign if_valid = if_valid_q;
    assign if_pc    = if_pc_q;
    assign if_instr = if_instr_q;
    assign halted   = (state_q == HALT);
    assign err      = err_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: a halting and a wrapping instance share stimulus;
// per-instance scoreboards check the fetched instruction stream.
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        load_valid = 1'b0;
    logic [6:0]  load_addr = 7'd0;
    logic [31:0] load_data = 32'd0;

    logic        a_load_ready, a_imem_we, a_if_valid, a_halted, a_err;
    logic [6:0]  a_imem_addr;
    logic [31:0] a_imem_wdata, a_imem_rdata, a_if_pc, a_if_instr;
    logic        b_load_ready, b_imem_we, b_if_valid, b_halted, b_err;
    logic [6:0]  b_imem_addr;
    logic [31:0] b_imem_wdata, b_imem_rdata, b_if_pc, b_if_instr;

    logic [31:0] mem_a [128];
    logic [31:0] mem_b [128];

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] q_a [$];
    logic [63:0] q_b [$];

    always #5 clk = ~clk;

    instr_fetch_ctrl #(.DEPTH(128), .ADDR_W(7), .WRAP_EN(0)) dut_a (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
        .load_ready(a_load_ready), .imem_addr(a_imem_addr), .imem_we(a_imem_we),
        .imem_wdata(a_imem_wdata), .imem_rdata(a_imem_rdata),
        .if_valid(a_if_valid), .if_pc(a_if_pc), .if_instr(a_if_instr),
        .halted(a_halted), .err(a_err)
    );

    instr_fetch_ctrl #(.DEPTH(128), .ADDR_W(7), .WRAP_EN(1)) dut_b (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
        .load_ready(b_load_ready), .imem_addr(b_imem_addr), .imem_we(b_imem_we),
        .imem_wdata(b_imem_wdata), .imem_rdata(b_imem_rdata),
        .if_valid(b_if_valid), .if_pc(b_if_pc), .if_instr(b_if_instr),
        .halted(b_halted), .err(b_err)
    );

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem_a[i] = 32'd0;
            mem_b[i] = 32'd0;
        end
    end

    assign a_imem_rdata = mem_a[a_imem_addr];
    assign b_imem_rdata = mem_b[b_imem_addr];

    always @(posedge clk) begin
        if (a_imem_we) mem_a[a_imem_addr] <= a_imem_wdata;
        if (b_imem_we) mem_b[b_imem_addr] <= b_imem_wdata;
    end

    function automatic logic [31:0] word_of(input int i);
        if (i == 0) return 32'h8C25_0003;
        if (i == 1) return 32'h00A1_2820;
        return 32'hA500_0000 | 32'(i);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_both(input int pc);
        q_a.push_back({32'(pc), word_of(pc)});
        q_b.push_back({32'(pc), word_of(pc)});
    endtask

    // A new fetch is any valid cycle whose PC differs from the previous valid one.
    logic        pv_a = 1'b0, pv_b = 1'b0;
    logic [31:0] pp_a = 32'd0, pp_b = 32'd0;

    always @(negedge clk) begin
        logic [63:0] e;
        if (a_if_valid && (!pv_a || a_if_pc != pp_a)) begin
            if (q_a.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL mon_a fetch: got pc %0d, expected no fetch", a_if_pc);
            end else begin
                e = q_a.pop_front();
                chk("mon_a pc", a_if_pc, e[63:32]);
                chk("mon_a instr", a_if_instr, e[31:0]);
            end
        end
        pv_a <= a_if_valid;
        pp_a <= a_if_pc;
    end

    always @(negedge clk) begin
        logic [63:0] e;
        if (b_if_valid && (!pv_b || b_if_pc != pp_b)) begin
            if (q_b.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL mon_b fetch: got pc %0d, expected no fetch", b_if_pc);
            end else begin
                e = q_b.pop_front();
                chk("mon_b pc", b_if_pc, e[63:32]);
                chk("mon_b instr", b_if_instr, e[31:0]);
            end
        end
        pv_b <= b_if_valid;
        pp_b <= b_if_pc;
    end

    initial begin
        // Reset with a coinciding load request
        load_valid = 1'b1;
        load_addr  = 7'd5;
        load_data  = 32'hDEAD_BEEF;
        #1;
        chk("rst imem_we", 32'(a_imem_we), 32'd0);
        chk("rst load_ready", 32'(a_load_ready), 32'd0);
        cyc();
        cyc();
        chk("rst if_valid", 32'(a_if_valid), 32'd0);
        chk("rst if_pc", a_if_pc, 32'd0);
        chk("rst if_instr", a_if_instr, 32'd0);
        chk("rst halted", 32'(a_halted), 32'd0);
        chk("rst err", 32'(b_err), 32'd0);
        chk("rst no write", mem_a[5], 32'd0);
        rst = 1'b0;

        // Program load
        for (int i = 0; i < 128; i++) begin
            load_valid = 1'b1;
            load_addr  = 7'(i);
            load_data  = word_of(i);
            if (i == 0) begin
                #1;
                chk("idle load_ready", 32'(a_load_ready), 32'd1);
                chk("idle imem_we", 32'(b_imem_we), 32'd1);
                chk("idle imem_wdata", a_imem_wdata, 32'h8C25_0003);
            end
            cyc();
        end

        // start is ignored while a load is pending
        start      = 1'b1;
        load_addr  = 7'd10;
        load_data  = word_of(10);
        cyc();
        start      = 1'b0;
        load_valid = 1'b0;
        cyc();
        chk("start blocked by load", 32'(a_if_valid), 32'd0);
        chk("loaded word 1", mem_a[1], 32'h00A1_2820);

        // Fetch, stall, redirect-with-stall
        push_both(0);
        push_both(1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("run entry if_valid", 32'(a_if_valid), 32'd0);
        cyc();
        chk("first fetch valid", 32'(a_if_valid), 32'd1);
        cyc();
        push_both(2);
        push_both(3);
        push_both(5);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("stall if_pc", a_if_pc, 32'd1);
            chk("stall if_instr", a_if_instr, 32'h00A1_2820);
            chk("stall if_valid", 32'(a_if_valid), 32'd1);
        end
        stall = 1'b0;
        cyc();
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'd5;
        stall          = 1'b1;
        cyc();
        chk("redirect bubble", 32'(a_if_valid), 32'd0);
        redirect_valid = 1'b0;
        stall          = 1'b0;
        cyc();

        // Load ignored in RUN; redirect toward end of memory
        load_valid     = 1'b1;
        load_addr      = 7'd3;
        load_data      = 32'h1234_5678;
        redirect_valid = 1'b1;
        redirect_pc    = 32'd120;
        #1;
        chk("run load_ready", 32'(a_load_ready), 32'd0);
        chk("run imem_we", 32'(a_imem_we), 32'd0);
        cyc();
        chk("redirect2 bubble", 32'(b_if_valid), 32'd0);
        load_valid     = 1'b0;
        redirect_valid = 1'b0;
        for (int p = 120; p < 128; p++) push_both(p);
        q_b.push_back({32'd0, word_of(0)});
        q_b.push_back({32'd1, word_of(1)});
        repeat (8) cyc();
        chk("pc127 not halted", 32'(a_halted), 32'd0);
        chk("pc127 delivered", a_if_pc, 32'd127);
        cyc();
        chk("end halted", 32'(a_halted), 32'd1);
        chk("end if_valid", 32'(a_if_valid), 32'd0);
        chk("wrap not halted", 32'(b_halted), 32'd0);
        chk("wrap if_pc", b_if_pc, 32'd0);
        cyc();

        // Reset mid-fetch
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst run if_valid", 32'(b_if_valid), 32'd0);
        chk("rst run if_pc", b_if_pc, 32'd0);
        chk("rst run if_instr", b_if_instr, 32'd0);
        chk("rst run halted", 32'(a_halted), 32'd0);
        chk("rst run imem_we", 32'(b_imem_we), 32'd0);
        chk("mem untouched in run", mem_a[3], word_of(3));

        // Out-of-range redirect
        start = 1'b1;
        cyc();
        start          = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'd200;
        cyc();
        redirect_valid = 1'b0;
        chk("oor err", 32'(a_err), 32'd1);
        chk("oor halted", 32'(b_halted), 32'd1);
        chk("oor if_valid", 32'(a_if_valid), 32'd0);
        start      = 1'b1;
        load_valid = 1'b1;
        #1;
        chk("halt load_ready", 32'(a_load_ready), 32'd0);
        repeat (2) cyc();
        chk("halt sticky", 32'(a_halted), 32'd1);
        chk("halt err sticky", 32'(b_err), 32'd1);
        chk("halt if_valid", 32'(b_if_valid), 32'd0);
        start      = 1'b0;
        load_valid = 1'b0;
        cyc();

        chk("scoreboard a drained", 32'(q_a.size()), 32'd0);
        chk("scoreboard b drained", 32'(q_b.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 128, meaning the number of instruction-memory words.
REQ-002 The block SHALL have parameter ADDR_W, default 7, meaning the memory index width, equal to log2(DEPTH).
REQ-003 The block SHALL have parameter WRAP_EN, default 0, meaning 1 = PC wraps DEPTH-1->0 and 0 = halt at end.
REQ-004 The block SHALL have the ports below:
- clk  in  1  clock; one clock.
- rst  in  1  reset; synchronous and active-high.
- start  in  1  leave IDLE and begin fetching at PC 0.
- stall  in  1  hold PC and fetch outputs (load-use hazard).
- redirect_valid  in  1  branch/jump taken.
- redirect_pc  in  32  new word-index PC.
- load_valid  in  1  program-load write request.
- load_addr  in  ADDR_W  program-load word index.
- load_data  in  32  program-load instruction word.
- load_ready  out  1  load write accepted this cycle.
- imem_addr  out  ADDR_W  memory word index.
- imem_we  out  1  memory write enable.
- imem_wdata  out  32  memory write data.
- imem_rdata  in  32  combinational read data at imem_addr.
- if_valid  out  1  if_instr/if_pc hold a valid fetched instruction.
- if_pc  out  32  PC of if_instr.
- if_instr  out  32  fetched instruction.
- halted  out  1  in HALT state.
- err  out  1  sticky; out-of-range redirect.

Function
REQ-005 The state machine SHALL have exactly three states: IDLE, RUN and HALT.
REQ-006 The block SHALL use a word-indexed PC that increments by 1 per fetch, with imem_addr = pc[ADDR_W-1:0].
REQ-007 In IDLE, load_ready SHALL equal load_valid, imem_we SHALL equal load_valid, imem_addr SHALL be load_addr, and imem_wdata SHALL be load_data.
REQ-008 In RUN and HALT, load_ready and imem_we SHALL be 0 and load requests SHALL be ignored, not queued.
REQ-009 start in IDLE SHALL take effect only when load_valid is 0; it sets pc=0 and moves the FSM to RUN next cycle.
REQ-010 start in RUN or HALT SHALL be ignored.
REQ-011 In RUN with stall=0 and redirect_valid=0, the block SHALL register if_instr<=imem_rdata, if_pc<=pc and if_valid<=1, and SHALL set pc<=pc+1, giving one-cycle fetch latency.
REQ-012 stall=1 with redirect_valid=0 SHALL hold pc, if_instr, if_pc and if_valid unchanged.
REQ-013 redirect_valid=1 with redirect_pc<DEPTH SHALL set pc<=redirect_pc and if_valid<=0 (one bubble); the fetch at the old PC is discarded.
REQ-014 redirect_valid=1 SHALL take priority over stall in the same cycle.
REQ-015 redirect_valid=1 with redirect_pc>=DEPTH SHALL set err<=1, set if_valid<=0, and move the FSM to HALT.
REQ-016 At the end of memory with WRAP_EN=0, a fetch at pc=DEPTH-1 SHALL complete normally and then the FSM SHALL move to HALT with if_valid<=0 on the following cycle.
REQ-017 At the end of memory with WRAP_EN=1, pc SHALL wrap from DEPTH-1 to 0.
REQ-018 HALT SHALL assert halted=1 and keep if_valid=0; only rst leaves HALT.
REQ-019 In IDLE, if_valid SHALL be 0.

Reset
REQ-020 rst=1 at a clock edge SHALL force state=IDLE and pc=0.
REQ-021 rst=1 at a clock edge SHALL force if_valid=0, if_pc=0, if_instr=0, halted=0 and err=0.
REQ-022 While rst=1, imem_we and load_ready SHALL be 0 combinationally.
REQ-023 Reset SHALL take effect mid-fetch or mid-load; a load write coinciding with rst SHALL NOT be performed.

Structure
REQ-024 The state encoding (IDLE/RUN/HALT) and the NOP constant 32'h0000_0000 SHALL reside in the shared package cpu_pkg.
REQ-025 The block SHALL contain one sub-module, pc_reg (PC register with hold/load/increment/wrap), and SHALL NOT contain the memory.

Verification
REQ-026 Load IMEM[0]=8C25_0003 and IMEM[1]=00A1_2820, then start -> if_valid rises 1 cycle after RUN entry, if_pc=0 with if_instr=8C25_0003, then if_pc=1 with 00A1_2820.
REQ-027 stall held for 3 cycles at if_pc=1 -> if_pc and if_instr are frozen for 3 cycles, then the next fetch is pc=2.
REQ-028 redirect_valid with redirect_pc=5 together with stall=1 -> one bubble (if_valid=0), then if_pc=5.
REQ-029 redirect_pc=200 -> err=1 and halted=1 next cycle, and if_valid stays 0.
REQ-030 WRAP_EN=0 running to pc=127 -> if_pc=127 is delivered and then HALT; with WRAP_EN=1, if_pc=127 is followed by if_pc=0.
REQ-031 load_valid during RUN -> load_ready=0 and imem_we=0; rst during RUN -> IDLE with all outputs at 0 next cycle.
